// File: rtl/wca_cic_interp_upconverter.sv
`default_nettype none
// ============================================================================
// Module   : wca_cic_interp_upconverter
// Brief    : Transmit CIC interpolator (N=3, M=1) from host-rate IQ to DAC rate
//            with shift, saturation and an rbus rate/gain register.
// Revision : 1.0 - initial release
// ============================================================================
// rbusCtrl layout: [11:4] byte address, [3:2] page (block answers page 0),
// [1] read strobe, [0] write strobe. The 16-bit config word lives at byte
// addresses 2*INTERP_RATE_ADDR (low) and 2*INTERP_RATE_ADDR+1 (high); the
// low byte is staged and the high-byte write commits the whole word.
module wca_cic_interp_upconverter #(
  parameter int INTERP_RATE_ADDR = 2,
  parameter int RMAX_LOG2        = 6,
  parameter int ACC_W            = 16 + 2*RMAX_LOG2
) (
  input  logic        clock,
  input  logic        ngreset,
  input  logic        enable,
  input  logic        dstrobe_out,
  input  logic [31:0] iq_in,
  input  logic        iq_valid,
  output logic        sample_req,
  output logic [23:0] iq_out,
  output logic        underflow,
  input  logic [11:0] rbusCtrl,
  inout  wire  [7:0]  rbusData
);

  localparam logic [6:0] c_WORD_ADDR = 7'(INTERP_RATE_ADDR);
  localparam logic [6:0] c_RMAX      = 7'(1 << RMAX_LOG2);
  localparam logic [6:0] c_RMIN      = 7'd2;
  localparam logic [3:0] c_SMAX      = 4'd12;

  // --------------------------------------------------------------------------
  // rbus register
  // --------------------------------------------------------------------------
  logic        w_hit, w_wr, w_rd, w_nd, w_cfg_pulse;
  logic [7:0]  w_rd_byte;
  logic        r_nd_d;
  logic [7:0]  r_cfg_lo;
  logic [15:0] r_cfg;

  assign w_hit       = (rbusCtrl[3:2] == 2'b00) && (rbusCtrl[11:5] == c_WORD_ADDR);
  assign w_wr        = w_hit & rbusCtrl[0];
  assign w_rd        = w_hit & rbusCtrl[1] & ~rbusCtrl[0];
  assign w_nd        = w_wr & rbusCtrl[4];
  assign w_cfg_pulse = w_nd & ~r_nd_d;
  assign w_rd_byte   = rbusCtrl[4] ? r_cfg[15:8] : r_cfg[7:0];
  assign rbusData    = w_rd ? w_rd_byte : 8'bz;

  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      r_nd_d   <= 1'b0;
      r_cfg_lo <= '0;
      r_cfg    <= '0;
    end else begin
      r_nd_d <= w_nd;
      if (w_wr && !rbusCtrl[4]) r_cfg_lo <= rbusData;
      if (w_cfg_pulse)          r_cfg    <= {rbusData, r_cfg_lo};
    end
  end

  logic [6:0] w_rate, w_rate_m1;
  logic [3:0] w_shift;

  always_comb begin
    w_rate = r_cfg[6:0];
    if (r_cfg[6:0] < c_RMIN)      w_rate = c_RMIN;
    else if (r_cfg[6:0] > c_RMAX) w_rate = c_RMAX;
    w_shift = (r_cfg[11:8] > c_SMAX) ? c_SMAX : r_cfg[11:8];
  end
  assign w_rate_m1 = w_rate - 7'd1;

  // --------------------------------------------------------------------------
  // Holding register, phase and slot control (shared by I and Q)
  // --------------------------------------------------------------------------
  logic        w_flush, w_strobe, w_slot, w_consume, w_load;
  logic        r_alive, r_full, r_stuff, r_underflow;
  logic [6:0]  r_phase;
  logic [31:0] r_hold;

  // A config commit flushes exactly like enable low, and wins over a strobe.
  assign w_flush    = ~enable | w_cfg_pulse;
  assign w_strobe   = dstrobe_out & ~w_flush;
  assign w_slot     = w_strobe & (r_phase == 7'd0);
  assign w_consume  = w_slot & r_full;
  assign w_load     = iq_valid & r_alive & (~r_full | w_consume);
  // r_alive keeps ready low through reset regardless of enable.
  assign sample_req = r_alive & enable & ~r_full;
  assign underflow  = r_underflow;

  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      r_alive     <= 1'b0;
      r_phase     <= '0;
      r_full      <= 1'b0;
      r_hold      <= '0;
      r_stuff     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_flush) begin
        r_phase     <= '0;
        r_full      <= 1'b0;
        r_hold      <= '0;
        r_stuff     <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_strobe) begin
          r_phase <= (r_phase >= w_rate_m1) ? 7'd0 : r_phase + 7'd1;
          r_stuff <= w_slot;
          if (w_slot && !r_full) r_underflow <= 1'b1;
        end
        if (w_load)         r_hold <= iq_in;
        if (w_load)         r_full <= 1'b1;
        else if (w_consume) r_full <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel comb / integrator / output datapath
  // --------------------------------------------------------------------------
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic signed [ACC_W-1:0] w_x, w_c1, w_c2, w_c3, w_shifted;
    logic signed [ACC_W-1:0] r_x, r_c1, r_c2, r_c3, r_i1, r_i2, r_i3;
    logic                    w_in_range;
    logic [11:0]             w_sat, r_y;

    assign w_x = r_full ? {{(ACC_W-16){r_hold[16*ch+15]}}, r_hold[16*ch +: 16]} : '0;
    // Whole comb chain settles within the slot; r_* hold the previous slot.
    assign w_c1 = w_x  - r_x;
    assign w_c2 = w_c1 - r_c1;
    assign w_c3 = w_c2 - r_c2;

    assign w_shifted  = r_i3 >>> w_shift;
    assign w_in_range = (&w_shifted[ACC_W-1:11]) | ~(|w_shifted[ACC_W-1:11]);
    assign w_sat      = w_in_range ? w_shifted[11:0]
                                   : {w_shifted[ACC_W-1], {11{~w_shifted[ACC_W-1]}}};

    always_ff @(posedge clock or negedge ngreset) begin
      if (!ngreset) begin
        r_x  <= '0; r_c1 <= '0; r_c2 <= '0; r_c3 <= '0;
        r_i1 <= '0; r_i2 <= '0; r_i3 <= '0; r_y  <= '0;
      end else if (w_flush) begin
        r_x  <= '0; r_c1 <= '0; r_c2 <= '0; r_c3 <= '0;
        r_i1 <= '0; r_i2 <= '0; r_i3 <= '0; r_y  <= '0;
      end else if (w_strobe) begin
        if (w_slot) begin
          r_x  <= w_x;
          r_c1 <= w_c1;
          r_c2 <= w_c2;
          r_c3 <= w_c3;
        end
        r_i1 <= r_i1 + (r_stuff ? r_c3 : '0);
        r_i2 <= r_i2 + r_i1;
        r_i3 <= r_i3 + r_i2;
        r_y  <= w_sat;
      end
    end

    assign iq_out[12*ch +: 12] = r_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_wca_cic_interp_upconverter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wca_cic_interp_upconverter
// Brief    : Directed bench with a convolution-based CIC reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wca_cic_interp_upconverter;

  logic        clock = 1'b0;
  logic        ngreset = 1'b0;
  logic        enable = 1'b1;
  logic        dstrobe_out = 1'b0;
  logic [31:0] iq_in = '0;
  logic        iq_valid = 1'b0;
  logic        sample_req, underflow;
  logic [23:0] iq_out;
  logic [11:0] rbusCtrl = '0;
  logic [7:0]  rb_drv = '0;
  logic        rb_oe = 1'b0;
  wire  [7:0]  rbusData;

  assign rbusData = rb_oe ? rb_drv : 8'hzz;

  wca_cic_interp_upconverter dut (
    .clock(clock), .ngreset(ngreset), .enable(enable), .dstrobe_out(dstrobe_out),
    .iq_in(iq_in), .iq_valid(iq_valid), .sample_req(sample_req), .iq_out(iq_out),
    .underflow(underflow), .rbusCtrl(rbusCtrl), .rbusData(rbusData)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe generator: one pulse every third clock while enabled.
  bit strobe_on = 0;
  int stb_cnt   = 0;
  always @(negedge clock) begin
    if (strobe_on) begin
      dstrobe_out = (stb_cnt == 0);
      stb_cnt = (stb_cnt + 1) % 3;
    end else begin
      dstrobe_out = 1'b0;
      stb_cnt = 0;
    end
  end

  // Source: offers queued samples first, then src_idle if src_repeat.
  bit          src_on = 0, src_repeat = 0;
  logic [31:0] src_idle = '0;
  logic [31:0] src_q[$];
  always @(negedge clock) begin
    if (src_on && (src_q.size() > 0 || src_repeat)) begin
      iq_valid = 1'b1;
      iq_in    = (src_q.size() > 0) ? src_q[0] : src_idle;
    end else begin
      iq_valid = 1'b0;
    end
  end

  // Reference model: output = saturate((sum of slot samples convolved with the
  // triple length-R box response, delayed 4 strobes) >>> S).
  typedef struct { int s; int xi; int xq; } slot_t;
  slot_t       slots[$];
  int          m_n = 0, m_R = 2, m_S = 0, m_phase = 0, strobe_idx = 0;
  logic [7:0]  m_cfg_lo = '0;
  bit          m_nd_d = 0, m_full = 0, m_alive = 0, m_uf = 0, strobe_now = 0;
  logic [31:0] m_hold = '0;
  logic [23:0] exp_iq = '0;

  function automatic int h(input int r, input int m);
    int cnt = 0;
    for (int a = 0; a < r; a++)
      for (int b = 0; b < r; b++)
        if (m - a - b >= 0 && m - a - b < r) cnt++;
    return cnt;
  endfunction

  function automatic logic [11:0] sat12(input longint y, input int s);
    longint v;
    v = y >>> s;
    if (v > 2047)  return 12'h7ff;
    if (v < -2048) return 12'h800;
    return v[11:0];
  endfunction

  always @(posedge clock or negedge ngreset) begin
    bit wr_lo, wr_hi, pulse, consume;
    longint yi, yq;
    int xi, xq, d;
    logic signed [15:0] ti, tq;
    if (!ngreset) begin
      m_full = 0; m_alive = 0; m_uf = 0; m_hold = '0; m_phase = 0; m_n = 0;
      m_R = 2; m_S = 0; m_cfg_lo = '0; m_nd_d = 0; strobe_now = 0;
      exp_iq = '0; slots.delete();
    end else begin
      strobe_now = 0;
      wr_lo = rbusCtrl[0] && rbusCtrl[3:2] == 2'b00 && rbusCtrl[11:4] == 8'd4;
      wr_hi = rbusCtrl[0] && rbusCtrl[3:2] == 2'b00 && rbusCtrl[11:4] == 8'd5;
      pulse = wr_hi && !m_nd_d;
      m_nd_d = wr_hi;
      if (pulse) begin
        m_R = (m_cfg_lo[6:0] < 2) ? 2 : (m_cfg_lo[6:0] > 64) ? 64 : int'(m_cfg_lo[6:0]);
        m_S = (rb_drv[3:0] > 12) ? 12 : int'(rb_drv[3:0]);
      end
      if (wr_lo) m_cfg_lo = rb_drv;
      if (!enable || pulse) begin
        m_full = 0; m_hold = '0; m_phase = 0; m_uf = 0; m_n = 0;
        exp_iq = '0; slots.delete();
      end else begin
        consume = 0;
        if (dstrobe_out) begin
          while (slots.size() > 0 && (m_n - slots[0].s - 4) > 3*m_R - 3)
            void'(slots.pop_front());
          yi = 0; yq = 0;
          foreach (slots[j]) begin
            d = m_n - slots[j].s - 4;
            if (d >= 0) begin
              yi += longint'(slots[j].xi) * h(m_R, d);
              yq += longint'(slots[j].xq) * h(m_R, d);
            end
          end
          exp_iq = {sat12(yq, m_S), sat12(yi, m_S)};
          strobe_now = 1;
          strobe_idx = m_n;
          if (m_phase == 0) begin
            ti = m_hold[15:0];
            tq = m_hold[31:16];
            xi = m_full ? int'(ti) : 0;
            xq = m_full ? int'(tq) : 0;
            slots.push_back('{m_n, xi, xq});
            if (!m_full) m_uf = 1;
            consume = m_full;
          end
          m_phase = (m_phase + 1) % m_R;
          m_n++;
        end
        if (iq_valid && m_alive && (!m_full || consume)) begin
          m_hold = iq_in;
          m_full = 1;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end else if (consume) begin
          m_full = 0;
        end
      end
      m_alive = 1;
    end
  end

  // Per-cycle comparison and per-strobe capture for the directed checks.
  logic [11:0] hist_i [0:255];
  logic [11:0] hist_q [0:255];
  logic        hist_sreq [0:255];
  always @(posedge clock) begin
    #1;
    check("iq_out", {8'h0, iq_out}, {8'h0, exp_iq});
    check("underflow", {31'h0, underflow}, {31'h0, m_uf});
    check("sample_req", {31'h0, sample_req}, {31'h0, m_alive & enable & ~m_full});
    if (strobe_now && strobe_idx < 256) begin
      hist_i[strobe_idx]    = iq_out[11:0];
      hist_q[strobe_idx]    = iq_out[23:12];
      hist_sreq[strobe_idx] = sample_req;
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rbus_write(input logic [7:0] baddr, input logic [7:0] data);
    @(negedge clock);
    rbusCtrl = {baddr, 4'b0001};
    rb_drv   = data;
    rb_oe    = 1'b1;
    clocks(2);
    rbusCtrl = '0;
    rb_oe    = 1'b0;
  endtask

  task automatic cfg_write(input logic [15:0] v);
    rbus_write(8'd4, v[7:0]);
    rbus_write(8'd5, v[15:8]);
  endtask

  task automatic wait_strobes(input int target);
    int cyc = 0;
    while (m_n < target && cyc < 4000) begin
      @(negedge clock);
      cyc++;
    end
    if (m_n < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_strobes: reached %0d, required %0d", m_n, target);
    end
  endtask

  // Stops strobes and source, reprograms, then restarts with a clean source.
  task automatic start_run(input logic [15:0] cfg, input logic [31:0] first_q[$],
                           input logic [31:0] idle);
    strobe_on = 0;
    src_on    = 0;
    clocks(2);
    cfg_write(cfg);
    src_q      = first_q;
    src_idle   = idle;
    src_repeat = 1;
    src_on     = 1;
    clocks(3);
    strobe_on  = 1;
  endtask

  initial begin
    logic [31:0] q_imp[$];
    logic [31:0] q_two[$];
    logic [31:0] q_none[$];
    q_imp  = '{32'd100};
    q_two  = '{32'd100, 32'd7};
    q_none = {};

    // Power-up reset
    clocks(3);
    check("rst_iq_out", {8'h0, iq_out}, 32'h0);
    check("rst_underflow", {31'h0, underflow}, 32'h0);
    check("rst_sample_req", {31'h0, sample_req}, 32'h0);
    ngreset = 1'b1;
    clocks(2);
    check("req_after_rst", {31'h0, sample_req}, 32'h1);

    // Impulse, R=2 S=0
    start_run(16'h0002, q_imp, 32'h0);
    wait_strobes(12);
    check("imp_i4", {20'h0, hist_i[4]}, 32'd100);
    check("imp_i5", {20'h0, hist_i[5]}, 32'd300);
    check("imp_i6", {20'h0, hist_i[6]}, 32'd300);
    check("imp_i7", {20'h0, hist_i[7]}, 32'd100);
    check("imp_i8", {20'h0, hist_i[8]}, 32'd0);
    check("imp_q5", {20'h0, hist_q[5]}, 32'd0);
    check("imp_q6", {20'h0, hist_q[6]}, 32'd0);

    // DC gain R^2 with shift, R=4 S=2
    start_run(16'h0204, q_none, {16'hff00, 16'h0100});
    wait_strobes(40);
    check("dc_i", {20'h0, iq_out[11:0]}, 32'h400);
    check("dc_q", {20'h0, iq_out[23:12]}, 32'hc00);

    // Enable low flushes and ignores strobes
    @(negedge clock);
    enable = 1'b0;
    clocks(10);
    check("dis_iq_out", {8'h0, iq_out}, 32'h0);
    check("dis_sample_req", {31'h0, sample_req}, 32'h0);
    enable = 1'b1;

    // Saturation, R=4 S=0
    start_run(16'h0004, q_none, {16'hff00, 16'h0100});
    wait_strobes(40);
    check("sat_i", {20'h0, iq_out[11:0]}, 32'h7ff);
    check("sat_q", {20'h0, iq_out[23:12]}, 32'h800);

    // Asynchronous reset mid-stream
    @(negedge clock);
    src_on = 0;
    @(posedge clock);
    #3;
    ngreset = 1'b0;
    #1;
    check("arst_iq_out", {8'h0, iq_out}, 32'h0);
    check("arst_underflow", {31'h0, underflow}, 32'h0);
    check("arst_sample_req", {31'h0, sample_req}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    ngreset = 1'b1;
    clocks(2);
    check("arst_req_release", {31'h0, sample_req}, 32'h1);

    // Underflow, R=8 S=6
    start_run(16'h0608, q_none, {16'hffce, 16'h0032});
    wait_strobes(48);
    check("uf_before", {31'h0, underflow}, 32'h0);
    check("uf_steady_i", {20'h0, iq_out[11:0]}, 32'h032);
    check("uf_steady_q", {20'h0, iq_out[23:12]}, 32'hfce);
    src_on = 0;
    wait_strobes(72);
    check("uf_set", {31'h0, underflow}, 32'h1);
    src_on = 1;
    wait_strobes(132);
    check("uf_sticky", {31'h0, underflow}, 32'h1);
    check("uf_resume_i", {20'h0, iq_out[11:0]}, 32'h032);

    // Rate change 4 -> 2 flushes state
    start_run(16'h0204, q_none, {16'hff00, 16'h0100});
    wait_strobes(30);
    src_on = 0;
    wait_strobes(42);
    check("rw_uf_pre", {31'h0, underflow}, 32'h1);
    strobe_on = 0;
    clocks(2);
    cfg_write(16'h0002);
    check("rw_iq_flushed", {8'h0, iq_out}, 32'h0);
    check("rw_uf_cleared", {31'h0, underflow}, 32'h0);
    src_q = q_imp;
    src_idle = 32'h0;
    src_on = 1;
    clocks(3);
    strobe_on = 1;
    wait_strobes(12);
    check("rw_i4", {20'h0, hist_i[4]}, 32'd100);
    check("rw_i5", {20'h0, hist_i[5]}, 32'd300);
    check("rw_i6", {20'h0, hist_i[6]}, 32'd300);
    check("rw_i7", {20'h0, hist_i[7]}, 32'd100);
    check("rw_i8", {20'h0, hist_i[8]}, 32'd0);

    // Same-clock consume and load, R=2 S=0
    start_run(16'h0002, q_two, 32'h0);
    wait_strobes(12);
    check("scl_req_at_slot", {31'h0, hist_sreq[0]}, 32'h0);
    check("scl_i4", {20'h0, hist_i[4]}, 32'd100);
    check("scl_i6", {20'h0, hist_i[6]}, 32'd307);
    check("scl_i7", {20'h0, hist_i[7]}, 32'd121);
    check("scl_i9", {20'h0, hist_i[9]}, 32'd7);

    strobe_on = 0;
    src_on = 0;
    clocks(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
